// File: rtl/jtag_tap_ctrl.sv
// IEEE 1149.1-style TAP controller: 16-state TAP FSM, instruction register,
// Moore data-register strobes and the registered chip TDO/TDO_EN.
// There is no valid/ready handshake here. Every input is sampled on each
// rising TCK edge. The FSM state is exposed on STATE_DBG so that checkers
// can bind to it.
module jtag_tap_ctrl #(
    parameter int                    IR_WIDTH   = 4,
    parameter logic [IR_WIDTH-1:0]   IR_RESET   = 4'h2,
    parameter logic [IR_WIDTH-1:0]   IR_CAPTURE = 4'h1,
    parameter logic [IR_WIDTH-1:0]   MAX_CODE   = 4'h5
) (
    input  logic                TCK,
    input  logic                RST,
    input  logic                TMS,
    input  logic                TDI,
    input  logic                DR_TDO,
    output logic [IR_WIDTH-1:0] IR_CODE,
    output logic                TLR,
    output logic                RUN_IDLE,
    output logic                CAPTURE_DR,
    output logic                SHIFT_DR,
    output logic                UPDATE_DR,
    output logic                TDO,
    output logic                TDO_EN,
    output logic [3:0]          STATE_DBG
);

    typedef enum logic [3:0] {
        S_TLR    = 4'd0,
        S_RTI    = 4'd1,
        S_SEL_DR = 4'd2,
        S_CAP_DR = 4'd3,
        S_SH_DR  = 4'd4,
        S_EX1_DR = 4'd5,
        S_PAU_DR = 4'd6,
        S_EX2_DR = 4'd7,
        S_UPD_DR = 4'd8,
        S_SEL_IR = 4'd9,
        S_CAP_IR = 4'd10,
        S_SH_IR  = 4'd11,
        S_EX1_IR = 4'd12,
        S_PAU_IR = 4'd13,
        S_EX2_IR = 4'd14,
        S_UPD_IR = 4'd15
    } tap_state_t;

    tap_state_t          state;
    tap_state_t          next_state;
    logic [IR_WIDTH-1:0] ir_sr;

    // State register. Reset always lands in Test-Logic-Reset.
    always_ff @(posedge TCK) begin
        if (RST) begin
            state <= S_TLR;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode from TMS, plus the Moore strobes decoded from the current state.
    always_comb begin
        next_state = state;
        TLR        = 1'b0;
        RUN_IDLE   = 1'b0;
        CAPTURE_DR = 1'b0;
        SHIFT_DR   = 1'b0;
        UPDATE_DR  = 1'b0;
        case (state)
            S_TLR:    next_state = TMS ? S_TLR    : S_RTI;
            S_RTI:    next_state = TMS ? S_SEL_DR : S_RTI;
            S_SEL_DR: next_state = TMS ? S_SEL_IR : S_CAP_DR;
            S_CAP_DR: next_state = TMS ? S_EX1_DR : S_SH_DR;
            S_SH_DR:  next_state = TMS ? S_EX1_DR : S_SH_DR;
            S_EX1_DR: next_state = TMS ? S_UPD_DR : S_PAU_DR;
            S_PAU_DR: next_state = TMS ? S_EX2_DR : S_PAU_DR;
            S_EX2_DR: next_state = TMS ? S_UPD_DR : S_SH_DR;
            S_UPD_DR: next_state = TMS ? S_SEL_DR : S_RTI;
            S_SEL_IR: next_state = TMS ? S_TLR    : S_CAP_IR;
            S_CAP_IR: next_state = TMS ? S_EX1_IR : S_SH_IR;
            S_SH_IR:  next_state = TMS ? S_EX1_IR : S_SH_IR;
            S_EX1_IR: next_state = TMS ? S_UPD_IR : S_PAU_IR;
            S_PAU_IR: next_state = TMS ? S_EX2_IR : S_PAU_IR;
            S_EX2_IR: next_state = TMS ? S_UPD_IR : S_SH_IR;
            S_UPD_IR: next_state = TMS ? S_SEL_DR : S_RTI;
            default:  next_state = S_TLR;
        endcase
        TLR        = (state == S_TLR);
        RUN_IDLE   = (state == S_RTI);
        CAPTURE_DR = (state == S_CAP_DR);
        SHIFT_DR   = (state == S_SH_DR);
        UPDATE_DR  = (state == S_UPD_DR);
    end

    assign STATE_DBG = state;

    // Instruction shift register and instruction latch. Entering TLR overrides
    // any update. Unimplemented codes decode to BYPASS.
    always_ff @(posedge TCK) begin
        if (RST) begin
            IR_CODE <= IR_RESET;
            ir_sr   <= IR_CAPTURE;
        end else begin
            if (next_state == S_TLR) begin
                IR_CODE <= IR_RESET;
            end else if (state == S_UPD_IR) begin
                IR_CODE <= (ir_sr > MAX_CODE) ? '0 : ir_sr;
            end
            if (state == S_CAP_IR) begin
                ir_sr <= IR_CAPTURE;
            end else if (state == S_SH_IR) begin
                ir_sr <= {TDI, ir_sr[IR_WIDTH-1:1]};
            end
        end
    end

    // Registered TDO path. TDO holds its last value whenever the enable is low.
    always_ff @(posedge TCK) begin
        if (RST) begin
            TDO    <= 1'b0;
            TDO_EN <= 1'b0;
        end else begin
            TDO_EN <= (state == S_SH_IR) || (state == S_SH_DR);
            if (state == S_SH_IR) begin
                TDO <= ir_sr[0];
            end else if (state == S_SH_DR) begin
                TDO <= DR_TDO;
            end
        end
    end

endmodule
